// File: rtl/hamming_pkg.sv
// Shared Hamming SECDED helpers: width derivation, codeword data-bit mapping and error classes.
package hamming_pkg;

  typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE} err_class_e;

  function automatic int parity_width(input int dw);
    return $clog2(dw) + 1;
  endfunction

  function automatic int enc_width(input int dw);
    return dw + parity_width(dw);
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword index of data bit j: data fills the non-power-of-two positions in order
  function automatic int data_idx(input int j);
    int idx = 0;
    int k   = 0;
    for (int i = 0; i < 256; i++) begin
      if (!is_pow2(i + 1)) begin
        if (k == j) idx = i;
        k++;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// Codeword-in / decoded-result-out handshake bundle for the SECDED decoder.
interface hamming_secded_decoder_if #(parameter int DATA_WIDTH = 8);
  localparam int CW_WIDTH  = hamming_pkg::enc_width(DATA_WIDTH) + 1;
  localparam int POS_WIDTH = $clog2(CW_WIDTH);

  logic                  i_valid;
  logic                  o_ready;
  logic [CW_WIDTH-1:0]   i_enc_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_single_err;
  logic                  o_double_err;
  logic [POS_WIDTH-1:0]  o_err_pos;

  modport slave (
    input  i_valid, i_enc_data, i_ready,
    output o_ready, o_valid, o_data, o_single_err, o_double_err, o_err_pos
  );

  modport master (
    output i_valid, i_enc_data, i_ready,
    input  o_ready, o_valid, o_data, o_single_err, o_double_err, o_err_pos
  );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of one extended codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [enc_width(DATA_WIDTH):0]        cw,
  output logic [parity_width(DATA_WIDTH)-1:0]   syndrome,
  output logic                                  parity
);
  localparam int PW  = parity_width(DATA_WIDTH);
  localparam int ENC = enc_width(DATA_WIDTH);

  // Syndrome bit b covers every position whose number has bit b set
  always_comb begin
    syndrome = '0;
    for (int i = 0; i < ENC; i++) begin
      for (int b = 0; b < PW; b++) begin
        if ((((i + 1) >> b) & 1) != 0) syndrome[b] = syndrome[b] ^ cw[i];
      end
    end
  end

  assign parity = ^cw;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder: S1 syndrome/parity, S2 classify/correct, with saturating error counters.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  hamming_secded_decoder_if.slave bus,
  input  logic                    i_clr_cnt,
  output logic [CNT_WIDTH-1:0]    o_sec_cnt,
  output logic [CNT_WIDTH-1:0]    o_ded_cnt
);
  localparam int PW        = parity_width(DATA_WIDTH);
  localparam int ENC       = enc_width(DATA_WIDTH);
  localparam int CW        = ENC + 1;
  localparam int POS_WIDTH = $clog2(CW);
  localparam int STAGES    = 2;

  logic [STAGES:1]       vld_pipe;
  logic                  s1_load, s2_adv, xfer;

  logic [PW-1:0]         syn_c;
  logic                  par_c;
  logic [DATA_WIDTH-1:0] ext_c;

  logic [DATA_WIDTH-1:0] s1_data;
  logic [PW-1:0]         s1_syn;
  logic                  s1_par;

  err_class_e            cls;
  logic [POS_WIDTH-1:0]  pos_c;
  logic [DATA_WIDTH-1:0] hit, data_c;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_single, out_double;
  logic [POS_WIDTH-1:0]  out_pos;

  assign s2_adv  = !vld_pipe[2] | bus.i_ready;
  assign s1_load = !vld_pipe[1] | s2_adv;
  assign xfer    = vld_pipe[2] & bus.i_ready;

  assign bus.o_ready      = s1_load;
  assign bus.o_valid      = vld_pipe[2];
  assign bus.o_data       = out_data;
  assign bus.o_single_err = out_single;
  assign bus.o_double_err = out_double;
  assign bus.o_err_pos    = out_pos;

  hamming_syndrome #(.DATA_WIDTH(DATA_WIDTH)) u_syn (
    .cw       (bus.i_enc_data),
    .syndrome (syn_c),
    .parity   (par_c)
  );

  // Only data positions are carried forward; a flip is applied in S2 if the syndrome points at one
  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_data
    localparam int DI = data_idx(j);
    assign ext_c[j] = bus.i_enc_data[DI];
    assign hit[j]   = (s1_syn == PW'(DI + 1));
  end

  always_comb begin
    cls   = ERR_NONE;
    pos_c = '0;
    if (s1_syn == '0) begin
      if (s1_par) begin
        cls   = ERR_SINGLE;
        pos_c = POS_WIDTH'(ENC);
      end
    end else if (s1_par && (int'(s1_syn) <= ENC)) begin
      cls   = ERR_SINGLE;
      pos_c = POS_WIDTH'(s1_syn - 1'b1);
    end else begin
      // even parity with nonzero syndrome, or a syndrome pointing past the codeword
      cls = ERR_DOUBLE;
    end
  end

  assign data_c = (cls == ERR_SINGLE) ? (s1_data ^ hit) : s1_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe   <= '0;
      out_data   <= '0;
      out_single <= 1'b0;
      out_double <= 1'b0;
      out_pos    <= '0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= bus.i_valid;
        if (bus.i_valid) begin
          s1_data <= ext_c;
          s1_syn  <= syn_c;
          s1_par  <= par_c;
        end
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_data   <= data_c;
          out_single <= (cls == ERR_SINGLE);
          out_double <= (cls == ERR_DOUBLE);
          out_pos    <= pos_c;
        end
      end
    end
  end

  // Clear beats a same-cycle increment; counts stick at all-ones
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_cnt) begin
      o_sec_cnt <= '0;
      o_ded_cnt <= '0;
    end else if (xfer) begin
      if (out_single && (o_sec_cnt != '1)) o_sec_cnt <= o_sec_cnt + 1'b1;
      if (out_double && (o_ded_cnt != '1)) o_ded_cnt <= o_ded_cnt + 1'b1;
    end
  end

endmodule
